bidir_shift_ctrl: RTL and testbench

- Command sequencer for the WIDTH-bit bidirectional shift register (mode/parallel-in/serial-in datapath).
- Accepts one command at a time over a valid/ready handshake: load, multi-bit shift right, multi-bit shift left, rotate right.
- Drives the register's mode, parallel input and serial inputs, and streams out the shifted-out bits.
- Sits between a host or bus-side controller and the register instance.

---
 rtl/bidir_shift_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_bidir_shift_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bidir_shift_ctrl.sv
// bidir_shift_ctrl: command sequencer for a WIDTH-bit bidirectional shift
// register. It accepts LOAD / SHIFT_RIGHT / SHIFT_LEFT / ROTATE_RIGHT commands
// over a valid/ready handshake, drives the register's mode, parallel input
// and serial inputs, and streams out the bits leaving the register.
//
// Optional feature macro: BIDIR_ROTATE_EN
//   defined   -> op 11 rotates right by cmd_cnt positions
//   undefined -> op 11 completes immediately with done_err=1, no register activity
module bidir_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic             abort,
  input  logic [WIDTH-1:0] reg_q,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] p_in,
  output logic             s_in_right,
  output logic             s_in_left,
  output logic             so_valid,
  output logic             so_bit,
  output logic             busy,
  output logic             done,
  output logic             done_abort,
  output logic             done_err,
  output logic [CNT_W-1:0] shifts_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SR   = 2'b01;
  localparam logic [1:0] OP_SL   = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SR   = 2'b01;
  localparam logic [1:0] MODE_SL   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

`ifdef BIDIR_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  // State and captured-command registers; reset returns everything to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: command capture, shift counting and abort handling.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        err_d   = 1'b0;
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          fill_d = cmd_fill;
          cnt_d  = '0;
          if (cmd_op == OP_LOAD) begin
            state_d = LOAD;
          end else if ((cmd_op == OP_ROR) && !ROT_EN) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (cmd_cnt == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
            cnt_d   = cmd_cnt;
          end
        end
      end
      LOAD: begin
        state_d = DONE;
      end
      SHIFT: begin
        if (abort) begin
          state_d = DONE;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register-side outputs decoded from state; abort masks the shift in the same cycle.
  always_comb begin
    mode       = MODE_HOLD;
    p_in       = '0;
    s_in_right = 1'b0;
    s_in_left  = 1'b0;
    so_valid   = 1'b0;
    so_bit     = 1'b0;
    case (state_q)
      LOAD: begin
        mode = MODE_LOAD;
        p_in = data_q;
      end
      SHIFT: begin
        if (!abort) begin
          case (op_q)
            OP_SR: begin
              mode       = MODE_SR;
              s_in_right = fill_q;
              so_valid   = 1'b1;
              so_bit     = reg_q[0];
            end
            OP_SL: begin
              mode      = MODE_SL;
              s_in_left = fill_q;
              so_valid  = 1'b1;
              so_bit    = reg_q[WIDTH-1];
            end
            OP_ROR: begin
              mode       = MODE_SR;
              s_in_right = reg_q[0];
              so_valid   = 1'b1;
              so_bit     = reg_q[0];
            end
            default: begin
              mode = MODE_HOLD;
            end
          endcase
        end
      end
      default: begin
        mode = MODE_HOLD;
      end
    endcase
  end

  // Handshake and status outputs.
  assign busy        = (state_q != IDLE);
  assign cmd_ready   = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign done_abort  = (state_q == DONE) && abort_q;
  assign done_err    = (state_q == DONE) && err_q;
  assign shifts_left = cnt_q;

endmodule

// File: tb/tb_bidir_shift_ctrl.sv
// tb_bidir_shift_ctrl: directed bench for bidir_shift_ctrl. A small
// behavioural shift register closes the loop on reg_q. Build with
// +define+BIDIR_ROTATE_EN to exercise the rotate feature.
module tb_bidir_shift_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;
  logic             abort;
  logic [WIDTH-1:0] regModel;
  logic [1:0]       mode;
  logic [WIDTH-1:0] p_in;
  logic             s_in_right;
  logic             s_in_left;
  logic             so_valid;
  logic             so_bit;
  logic             busy;
  logic             done;
  logic             done_abort;
  logic             done_err;
  logic [CNT_W-1:0] shifts_left;

  int checkCount = 0;
  int errorCount = 0;

  bidir_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_cnt     (cmd_cnt),
    .cmd_data    (cmd_data),
    .cmd_fill    (cmd_fill),
    .abort       (abort),
    .reg_q       (regModel),
    .mode        (mode),
    .p_in        (p_in),
    .s_in_right  (s_in_right),
    .s_in_left   (s_in_left),
    .so_valid    (so_valid),
    .so_bit      (so_bit),
    .busy        (busy),
    .done        (done),
    .done_abort  (done_abort),
    .done_err    (done_err),
    .shifts_left (shifts_left)
  );

  always #5 clk = ~clk;

  // Behavioural bidirectional shift register: 00 hold, 01 right, 10 left, 11 load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regModel <= '0;
    end else begin
      case (mode)
        2'b01:   regModel <= {s_in_right, regModel[WIDTH-1:1]};
        2'b10:   regModel <= {regModel[WIDTH-2:0], s_in_left};
        2'b11:   regModel <= p_in;
        default: regModel <= regModel;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Presents one command at a negedge; returns at the negedge of cycle 1.
  task automatic applyStimulus(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                               input logic [WIDTH-1:0] data, input logic fill);
    checkOutput("accept_ready", 32'(cmd_ready), 1);
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    cmd_fill  = fill;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_cnt   = ~cnt;
    cmd_data  = ~data;
    cmd_fill  = ~fill;
    @(negedge clk);
  endtask

  task automatic loadReg(input logic [WIDTH-1:0] data);
    applyStimulus(2'b00, 4'd0, data, 1'b0);
    nextCycle();
    nextCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic soExp [4];
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_cnt   = '0;
    cmd_data  = '0;
    cmd_fill  = 1'b0;
    abort     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_mode", 32'(mode), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_ready", 32'(cmd_ready), 1);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_shifts_left", 32'(shifts_left), 0);
    checkOutput("rst_so_valid", 32'(so_valid), 0);
    checkOutput("rst_p_in", 32'(p_in), 0);
    rst_n = 1'b1;
    nextCycle();

    // LOAD 1011
    applyStimulus(2'b00, 4'd0, 4'b1011, 1'b0);
    checkOutput("load_mode", 32'(mode), 'b11);
    checkOutput("load_p_in", 32'(p_in), 'b1011);
    checkOutput("load_busy", 32'(busy), 1);
    checkOutput("load_ready", 32'(cmd_ready), 0);
    checkOutput("load_reg_before", 32'(regModel), 0);
    nextCycle();
    checkOutput("load_done", 32'(done), 1);
    checkOutput("load_reg", 32'(regModel), 'b1011);
    checkOutput("load_done_mode", 32'(mode), 0);
    checkOutput("load_done_ready", 32'(cmd_ready), 0);
    nextCycle();
    checkOutput("load_ready_back", 32'(cmd_ready), 1);
    checkOutput("load_done_clear", 32'(done), 0);
    checkOutput("load_busy_clear", 32'(busy), 0);

    // SHIFT_RIGHT cnt=3 fill=0 on 1011
    loadReg(4'b1011);
    applyStimulus(2'b01, 4'd3, 4'b0000, 1'b0);
    soExp = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      checkOutput("sr_so_valid", 32'(so_valid), 1);
      checkOutput("sr_so_bit", 32'(so_bit), 32'(soExp[i]));
      checkOutput("sr_mode", 32'(mode), 'b01);
      checkOutput("sr_shifts_left", 32'(shifts_left), 32'(3 - i));
      checkOutput("sr_no_done", 32'(done), 0);
      nextCycle();
    end
    checkOutput("sr_done", 32'(done), 1);
    checkOutput("sr_reg", 32'(regModel), 'b0001);
    checkOutput("sr_done_so_valid", 32'(so_valid), 0);
    checkOutput("sr_done_abort", 32'(done_abort), 0);
    nextCycle();

    // SHIFT_LEFT cnt=2 fill=1 on 1011
    loadReg(4'b1011);
    applyStimulus(2'b10, 4'd2, 4'b0000, 1'b1);
    soExp = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      checkOutput("sl_so_bit", 32'(so_bit), 32'(soExp[i]));
      checkOutput("sl_mode", 32'(mode), 'b10);
      checkOutput("sl_s_in_left", 32'(s_in_left), 1);
      checkOutput("sl_s_in_right", 32'(s_in_right), 0);
      nextCycle();
    end
    checkOutput("sl_done", 32'(done), 1);
    checkOutput("sl_reg", 32'(regModel), 'b1111);
    checkOutput("sl_done_abort", 32'(done_abort), 0);
    nextCycle();

    // SHIFT_RIGHT cnt=5 aborted in the second shift cycle
    loadReg(4'b1011);
    applyStimulus(2'b01, 4'd5, 4'b0000, 1'b0);
    checkOutput("ab_first_so_bit", 32'(so_bit), 1);
    checkOutput("ab_first_shifts_left", 32'(shifts_left), 5);
    nextCycle();
    abort = 1'b1;
    #1;
    checkOutput("ab_mode_masked", 32'(mode), 0);
    checkOutput("ab_so_valid_masked", 32'(so_valid), 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("ab_done", 32'(done), 1);
    checkOutput("ab_done_abort", 32'(done_abort), 1);
    checkOutput("ab_shifts_left", 32'(shifts_left), 4);
    checkOutput("ab_reg", 32'(regModel), 'b0101);
    nextCycle();
    checkOutput("ab_flag_clear", 32'(done_abort), 0);

    // ROTATE_RIGHT cnt=4 on 1011
    loadReg(4'b1011);
    applyStimulus(2'b11, 4'd4, 4'b0000, 1'b0);
`ifdef BIDIR_ROTATE_EN
    soExp = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      checkOutput("ror_so_bit", 32'(so_bit), 32'(soExp[i]));
      checkOutput("ror_s_in_right", 32'(s_in_right), 32'(soExp[i]));
      checkOutput("ror_mode", 32'(mode), 'b01);
      nextCycle();
    end
    checkOutput("ror_done", 32'(done), 1);
    checkOutput("ror_done_err", 32'(done_err), 0);
    checkOutput("ror_reg", 32'(regModel), 'b1011);
`else
    checkOutput("ror_done", 32'(done), 1);
    checkOutput("ror_done_err", 32'(done_err), 1);
    checkOutput("ror_mode", 32'(mode), 0);
    checkOutput("ror_shifts_left", 32'(shifts_left), 0);
    checkOutput("ror_reg", 32'(regModel), 'b1011);
`endif
    nextCycle();
    checkOutput("ror_err_clear", 32'(done_err), 0);

    // SHIFT_RIGHT cnt=0 completes without register activity
    applyStimulus(2'b01, 4'd0, 4'b0000, 1'b1);
    checkOutput("cnt0_done", 32'(done), 1);
    checkOutput("cnt0_mode", 32'(mode), 0);
    checkOutput("cnt0_so_valid", 32'(so_valid), 0);
    checkOutput("cnt0_done_err", 32'(done_err), 0);
    checkOutput("cnt0_reg", 32'(regModel), 'b1011);
    nextCycle();
    checkOutput("cnt0_ready", 32'(cmd_ready), 1);

    // Reset asserted mid-SHIFT acts without a clock edge
    applyStimulus(2'b01, 4'd8, 4'b0000, 1'b0);
    nextCycle();
    checkOutput("mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_mode", 32'(mode), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_done", 32'(done), 0);
    checkOutput("mid_rst_shifts_left", 32'(shifts_left), 0);
    checkOutput("mid_rst_ready", 32'(cmd_ready), 1);
    checkOutput("mid_rst_so_valid", 32'(so_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("post_rst_ready", 32'(cmd_ready), 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
